// File: rtl/dmem_timer_responder.sv
// Data memory plus machine-timer MMIO responder for a single-cycle RV32 core.
// Ports: clock, reset (sync, active-high); addr, w_data, w_en, funct3 in;
//        r_data (combinational load data), int_req (registered timer irq) out.

module dmem_timer_responder #(
   parameter int MEM_WORDS = 1024
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic [31:0] w_data,
   input  logic        w_en,
   input  logic [2:0]  funct3,
   output logic [31:0] r_data,
   output logic        int_req
);

   localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   localparam logic [32:0] RAM_BYTES = 33'(MEM_WORDS) << 2;

   logic [31:0] r_mem [MEM_WORDS];
   logic [63:0] r_mtime;
   logic [63:0] r_mtimecmp;
   logic        r_enable;
   logic        r_pending;

   logic          w_is_ram;
   logic          w_is_mmio;
   logic [AW-1:0] w_idx;
   logic [31:0]   w_word;
   logic [7:0]    w_byte;
   logic [15:0]   w_half;
   logic [3:0]    w_be;
   logic [31:0]   w_wdat;
   logic          w_wr_mmio;
   logic          w_wr_mtlo;
   logic          w_wr_mthi;
   logic          w_wr_cmplo;
   logic          w_wr_cmphi;
   logic          w_wr_ctrl;
   logic          w_match;

   assign w_is_ram  = ({1'b0, addr} < RAM_BYTES);
   assign w_is_mmio = (addr[31:5] == 27'h4000000);
   assign w_idx     = addr[AW+1:2];

   // Raw 32-bit word behind the address
   always_comb begin
      w_word = '0;
      if (w_is_ram) begin
         w_word = r_mem[w_idx];
      end else if (w_is_mmio) begin
         case (addr[4:2])
            3'd0:    w_word = r_mtime[31:0];
            3'd1:    w_word = r_mtime[63:32];
            3'd2:    w_word = r_mtimecmp[31:0];
            3'd3:    w_word = r_mtimecmp[63:32];
            3'd4:    w_word = {30'b0, r_pending, r_enable};
            default: w_word = '0;
         endcase
      end
   end

   // Lane selection and sign/zero extension
   always_comb begin
      case (addr[1:0])
         2'd0:    w_byte = w_word[7:0];
         2'd1:    w_byte = w_word[15:8];
         2'd2:    w_byte = w_word[23:16];
         default: w_byte = w_word[31:24];
      endcase
      w_half = addr[1] ? w_word[31:16] : w_word[15:0];
      case (funct3)
         3'b000:  r_data = {{24{w_byte[7]}}, w_byte};
         3'b001:  r_data = {{16{w_half[15]}}, w_half};
         3'b010:  r_data = w_word;
         3'b100:  r_data = {24'b0, w_byte};
         3'b101:  r_data = {16'b0, w_half};
         default: r_data = '0;
      endcase
   end

   // Store lane enables; data replicated so each lane sees its bytes
   always_comb begin
      w_be   = 4'b0000;
      w_wdat = w_data;
      case (funct3)
         3'b000: begin
            w_be   = 4'b0001 << addr[1:0];
            w_wdat = {4{w_data[7:0]}};
         end
         3'b001: begin
            w_be   = addr[1] ? 4'b1100 : 4'b0011;
            w_wdat = {2{w_data[15:0]}};
         end
         3'b010:  w_be = 4'b1111;
         default: w_be = 4'b0000;
      endcase
   end

   always_ff @(posedge clock) begin
      if (w_en && w_is_ram && !reset) begin
         for (int i = 0; i < 4; i++) begin
            if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdat[8*i +: 8];
         end
      end
   end

   // Timer registers accept word stores only
   assign w_wr_mmio  = w_en && w_is_mmio && (funct3 == 3'b010);
   assign w_wr_mtlo  = w_wr_mmio && (addr[4:2] == 3'd0);
   assign w_wr_mthi  = w_wr_mmio && (addr[4:2] == 3'd1);
   assign w_wr_cmplo = w_wr_mmio && (addr[4:2] == 3'd2);
   assign w_wr_cmphi = w_wr_mmio && (addr[4:2] == 3'd3);
   assign w_wr_ctrl  = w_wr_mmio && (addr[4:2] == 3'd4);

   assign w_match = r_enable && (r_mtime >= r_mtimecmp);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_mtime    <= '0;
         r_mtimecmp <= '1;
         r_enable   <= 1'b0;
         r_pending  <= 1'b0;
      end else begin
         // A software write to either half suppresses the tick
         if (w_wr_mtlo)
            r_mtime <= {r_mtime[63:32], w_data};
         else if (w_wr_mthi)
            r_mtime <= {w_data, r_mtime[31:0]};
         else if (r_enable)
            r_mtime <= r_mtime + 64'd1;

         if (w_wr_cmplo) r_mtimecmp[31:0]  <= w_data;
         if (w_wr_cmphi) r_mtimecmp[63:32] <= w_data;

         if (w_wr_ctrl) r_enable <= w_data[0];

         // Set beats the W1C clear in the same cycle
         if (w_match)
            r_pending <= 1'b1;
         else if (w_wr_ctrl && w_data[1])
            r_pending <= 1'b0;
      end
   end

   assign int_req = r_pending;

endmodule

// File: tb/tb_dmem_timer_responder.sv
// Directed-vector bench for dmem_timer_responder.
// Expected values are queued by the stimulus and checked by a monitor.

module tb_dmem_timer_responder;

   logic        clock;
   logic        reset;
   logic [31:0] addr;
   logic [31:0] w_data;
   logic        w_en;
   logic [2:0]  funct3;
   logic [31:0] r_data;
   logic        int_req;

   dmem_timer_responder #(.MEM_WORDS(1024)) dut (
      .clock   (clock),
      .reset   (reset),
      .addr    (addr),
      .w_data  (w_data),
      .w_en    (w_en),
      .funct3  (funct3),
      .r_data  (r_data),
      .int_req (int_req)
   );

   typedef struct {
      bit          is_irq;
      logic [31:0] val;
      string       name;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   logic r_chk  = 1'b0;

   localparam logic [2:0] FB  = 3'b000;
   localparam logic [2:0] FH  = 3'b001;
   localparam logic [2:0] FW  = 3'b010;
   localparam logic [2:0] FBU = 3'b100;
   localparam logic [2:0] FHU = 3'b101;

   localparam logic [31:0] MT_LO  = 32'h8000_0000;
   localparam logic [31:0] MT_HI  = 32'h8000_0004;
   localparam logic [31:0] CMP_LO = 32'h8000_0008;
   localparam logic [31:0] CMP_HI = 32'h8000_000C;
   localparam logic [31:0] CTRL   = 32'h8000_0010;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, queue=%0d", q.size());
      $fatal(1, "watchdog");
   end

   // Monitor: inputs change just after posedge, so negedge sees settled data
   always @(negedge clock) begin
      if (r_chk) begin
         if (q.size() == 0) begin
            errors++;
            $display("FAIL monitor: strobe with empty queue");
         end else begin
            exp_t e;
            logic [31:0] act;
            e = q.pop_front();
            act = e.is_irq ? {31'b0, int_req} : r_data;
            checks++;
            if (act !== e.val) begin
               errors++;
               $display("FAIL %s: got %h expected %h", e.name, act, e.val);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic st(input logic [31:0] a, input logic [31:0] d,
                     input logic [2:0] f);
      addr   = a;
      w_data = d;
      funct3 = f;
      w_en   = 1'b1;
      r_chk  = 1'b0;
      tick();
      w_en   = 1'b0;
   endtask

   task automatic ld(input logic [31:0] a, input logic [2:0] f,
                     input logic [31:0] exp, input string nm);
      exp_t e;
      addr   = a;
      funct3 = f;
      w_en   = 1'b0;
      e.is_irq = 1'b0;
      e.val    = exp;
      e.name   = nm;
      q.push_back(e);
      r_chk  = 1'b1;
      tick();
      r_chk  = 1'b0;
   endtask

   task automatic irq(input logic exp, input string nm);
      exp_t e;
      w_en   = 1'b0;
      e.is_irq = 1'b1;
      e.val    = {31'b0, exp};
      e.name   = nm;
      q.push_back(e);
      r_chk  = 1'b1;
      tick();
      r_chk  = 1'b0;
   endtask

   initial begin
      reset  = 1'b1;
      addr   = '0;
      w_data = '0;
      w_en   = 1'b0;
      funct3 = FW;
      tick();
      tick();
      // Reset values visible combinationally while reset is held
      ld(CMP_LO, FW, 32'hFFFF_FFFF, "rst_cmp_lo");
      ld(CTRL,   FW, 32'h0,         "rst_ctrl");
      irq(1'b0, "rst_irq");
      reset = 1'b0;

      // RAM byte/half/word access
      st(32'h10, 32'h1122_3344, FW);
      ld(32'h13, FB,  32'h0000_0011, "lb_13");
      ld(32'h12, FH,  32'h0000_1122, "lh_12");
      st(32'h11, 32'h0000_00FF, FB);
      ld(32'h11, FB,  32'hFFFF_FFFF, "lb_11");
      ld(32'h11, FBU, 32'h0000_00FF, "lbu_11");
      ld(32'h10, FW,  32'h1122_FF44, "lw_10");
      ld(32'h10, FH,  32'hFFFF_FF44, "lh_10");
      ld(32'h12, FHU, 32'h0000_1122, "lhu_12");
      ld(32'h10, 3'b011, 32'h0,      "f3_011");

      st(32'h20, 32'h5566_7788, FW);
      st(32'h22, 32'h1234_8001, FH);
      ld(32'h22, FH,  32'hFFFF_8001, "lh_22");
      ld(32'h20, FHU, 32'h0000_7788, "lhu_20");
      ld(32'h20, FW,  32'h8001_7788, "lw_20");
      st(32'h20, 32'hAAAA_AAAA, 3'b011);
      ld(32'h23, FW,  32'h8001_7788, "lw_23_unaligned");

      // Decode boundaries
      st(32'h0,   32'h0,         FW);
      st(32'hFFC, 32'hCAFE_F00D, FW);
      st(32'h1000, 32'hDEAD_BEEF, FW);
      ld(32'hFFC, FW,  32'hCAFE_F00D, "lw_last_word");
      ld(32'h1000, FW, 32'h0,         "lw_past_ram");
      ld(32'h0,   FW,  32'h0,         "lw_0_no_alias");

      // Timer count and interrupt
      st(CMP_LO, 32'd5, FW);
      st(CMP_HI, 32'd0, FW);
      st(CTRL,   32'd1, FW);
      ld(MT_LO, FW, 32'd0, "mt_0");
      ld(MT_LO, FW, 32'd1, "mt_1");
      irq(1'b0, "irq_mt2");
      ld(MT_LO, FW, 32'd3, "mt_3");
      ld(MT_LO, FW, 32'd4, "mt_4");
      irq(1'b0, "irq_mt5");
      irq(1'b1, "irq_mt6");
      ld(CTRL,  FW, 32'h3, "ctrl_pend");
      ld(MT_HI, FW, 32'h0, "mt_hi_0");

      // W1C against a live match, then cleared once compare moves away
      st(CTRL, 32'h3, FW);
      irq(1'b1, "w1c_set_wins");
      st(CMP_HI, 32'hFFFF_FFFF, FW);
      irq(1'b1, "cmp_wr_keeps_pend");
      st(CTRL, 32'h3, FW);
      irq(1'b0, "w1c_clears");
      ld(CTRL,   FW, 32'h1,         "ctrl_en_only");
      ld(CMP_HI, FW, 32'hFFFF_FFFF, "cmp_hi_rd");

      // Sub-word MMIO stores ignored; sub-word MMIO loads extend
      st(CTRL,   32'h0,         FB);
      st(CMP_LO, 32'h0000_0099, FH);
      ld(CTRL,   FW, 32'h1,          "sb_ctrl_ignored");
      ld(CMP_LO, FW, 32'h5,          "sh_cmp_ignored");
      ld(CMP_HI, FB, 32'hFFFF_FFFF,  "mmio_lb");
      ld(32'h8000_000D, FBU, 32'hFF, "mmio_lbu");
      ld(32'h8000_0014, FW, 32'h0,   "mmio_rsvd");

      // mtime writes and carry
      st(MT_LO, 32'hFFFF_FFFF, FW);
      ld(MT_HI, FW, 32'h0, "carry_pre");
      ld(MT_HI, FW, 32'h1, "carry_hi");
      ld(MT_LO, FW, 32'h1, "carry_lo");
      st(MT_LO, 32'd7, FW);
      ld(MT_LO, FW, 32'd7, "mtwr_7");
      ld(MT_LO, FW, 32'd8, "mtwr_8");
      ld(MT_HI, FW, 32'h1, "mtwr_hi_kept");
      st(MT_HI, 32'hFFFF_FFFF, FW);
      st(MT_LO, 32'hFFFF_FFFE, FW);
      ld(MT_LO, FW, 32'hFFFF_FFFE, "wrap_fe");
      ld(MT_HI, FW, 32'hFFFF_FFFF, "wrap_ff_hi");
      ld(MT_HI, FW, 32'h0,         "wrap_hi_0");
      ld(MT_LO, FW, 32'h1,         "wrap_lo_1");
      irq(1'b1, "wrap_pend");

      // Reset mid-count with a concurrent store
      reset  = 1'b1;
      addr   = MT_LO;
      w_data = 32'h1234;
      funct3 = FW;
      w_en   = 1'b1;
      tick();
      w_en   = 1'b0;
      reset  = 1'b0;
      irq(1'b0, "rst2_irq");
      ld(MT_LO,  FW, 32'h0,         "rst2_mt");
      ld(CTRL,   FW, 32'h0,         "rst2_ctrl");
      ld(32'h10, FW, 32'h1122_FF44, "rst2_ram");
      ld(CMP_LO, FW, 32'hFFFF_FFFF, "rst2_cmp");
      st(MT_LO,  32'h55, FB);
      ld(MT_LO,  FW, 32'h0,         "sb_mt_ignored");
      st(32'h4000_0000, 32'h99, FW);
      ld(32'h4000_0000, FW, 32'h0,  "unmapped_lw");
      ld(32'h4000_0000, FB, 32'h0,  "unmapped_lb");

      tick();
      tick();
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dmem_timer_responder.md
DMEM_TIMER_RESPONDER -- requirements
Module: dmem_timer_responder

Interface
REQ-001 Parameter MEM_WORDS, default 1024, number of 32-bit RAM words mapped from address 0x00000000.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 addr  input  32  byte address from the CPU load/store port.
REQ-005 w_data  input  32  store data, rs2 value, unshifted.
REQ-006 w_en  input  1  store strobe; 1 = store this cycle.
REQ-007 funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 r_data  output  32  load data, extended per funct3.
REQ-009 int_req  output  1  machine timer interrupt request, level.

Function
REQ-010 Decode: RAM when addr < MEM_WORDS*4; MMIO when addr[31:5] == 27'h4000000 (0x80000000-0x8000001F); all else unmapped.
REQ-011 Alignment: W ignores addr[1:0]; H uses addr[1], ignores addr[0]; B uses addr[1:0]; little-endian lanes.
REQ-012 Reads SHALL be combinational, zero latency: r_data valid in the same cycle as addr/funct3, independent of w_en.
REQ-013 Load extraction: B/H sign-extend selected byte/halfword; BU/HU zero-extend; W passes 32 bits; funct3 011/110/111 return 0.
REQ-014 RAM store on rising edge when w_en=1: SB writes one byte lane with w_data[7:0]; SH writes two lanes with w_data[15:0]; SW writes all lanes; other funct3 writes nothing.
REQ-015 MMIO map (word offsets): 0x00 mtime[31:0], 0x04 mtime[63:32], 0x08 mtimecmp[31:0], 0x0C mtimecmp[63:32], 0x10 ctrl {30'b0, pending, enable}; 0x14-0x1C read 0, writes ignored.
REQ-016 MMIO stores SHALL take effect only with funct3=010; B/H stores to MMIO ignored. MMIO loads of any size apply REQ-013 to the 32-bit register value.
REQ-017 Unmapped loads return 0; unmapped stores have no effect.
REQ-018 mtime: 64-bit counter, increments by 1 each cycle while enable=1, wraps 0xFFFFFFFF_FFFFFFFF -> 0; holds while enable=0.
REQ-019 Store to either mtime half replaces that half with w_data that cycle; increment suppressed that cycle (write wins, no carry into other half).
REQ-020 Compare: match = enable & (mtime >= mtimecmp), unsigned 64-bit, using registered values before the edge.
REQ-021 pending SHALL set on the edge after match=1 and stay set (sticky).
REQ-022 Store to ctrl: bit0 writes enable; bit1=1 clears pending (W1C), bit1=0 no effect.
REQ-023 Simultaneous set (match=1) and W1C clear in one cycle: set wins, pending stays 1.
REQ-024 int_req SHALL equal pending (registered, no combinational path from inputs).
REQ-025 A store to mtimecmp updates compare from the following cycle onward; it does not clear pending.

Reset
REQ-026 On clock edge with reset=1: mtime=0, mtimecmp=0xFFFFFFFF_FFFFFFFF, enable=0, pending=0, int_req=0; stores that cycle are discarded.
REQ-027 RAM contents are not reset; r_data remains combinational during reset (RAM data or MMIO reset values).
REQ-028 Reset asserted mid-count SHALL clear timer state on that edge regardless of concurrent stores or match.

Verification
REQ-029 SW 0x11223344 to 0x10, then LB 0x13 -> 0x00000011; LH 0x12 -> 0x00001122; SB 0xFF to 0x11, LB 0x11 -> 0xFFFFFFFF, LBU 0x11 -> 0x000000FF, LW 0x10 -> 0x1122FF44.
REQ-030 SH 0x8001 to 0x22, LH 0x22 -> 0xFFFF8001, LHU 0x20 -> low half unchanged, LW 0x20 -> 0x8001xxxx with low half intact.
REQ-031 After reset, SW mtimecmp lo=5/hi=0, SW ctrl=1 -> mtime reads 0,1,2... per cycle; int_req rises the edge after mtime reaches 5 and stays 1.
REQ-032 With pending=1 and mtime>=mtimecmp, SW ctrl=0x3 -> int_req stays 1; SW mtimecmp hi=0xFFFFFFFF then SW ctrl=0x3 -> int_req falls next edge.
REQ-033 SW mtime lo=0xFFFFFFFF, hi=0, enable=1 -> next cycles mtime = 0x1_00000000; SW mtime lo=7 while counting -> reads 7 next cycle, 8 after.
REQ-034 Reset pulse while enable=1, pending=1 -> next cycle int_req=0, mtime=0, ctrl reads 0, RAM word written earlier still reads back unchanged; SB to 0x80000000 and load from 0x40000000 -> no state change, r_data=0.
